// File: rtl/uart_frame_scheduler.sv
// Round-robin scheduler that frames one channel's sample as {tag|index, sample bytes MSB first}
// and feeds it byte by byte into a shared UART_Tx send/data/busy handshake.
module uart_frame_scheduler #(
    parameter int         C_CHANNELS     = 4,
    parameter int         C_SAMPLE_WIDTH = 16,
    parameter logic [3:0] C_HEADER_TAG   = 4'hA,
    parameter int         C_TIMEOUT      = 8
) (
    input  logic                                 clk,
    input  logic                                 rstb,
    input  logic [C_CHANNELS-1:0]                req,
    input  logic [C_CHANNELS*C_SAMPLE_WIDTH-1:0] sample,
    output logic [C_CHANNELS-1:0]                ack,
    output logic                                 tx_send,
    output logic [7:0]                           tx_data,
    input  logic                                 tx_busy,
    output logic                                 frame_active,
    output logic                                 error
);
    localparam int NB = 1 + C_SAMPLE_WIDTH / 8;
    localparam int CW = (C_CHANNELS > 1) ? $clog2(C_CHANNELS) : 1;
    localparam logic [C_CHANNELS-1:0] ACK_ONE = C_CHANNELS'(1);

    typedef enum logic [2:0] {sIDLE, sGRANT, sSEND, sWAITHI, sWAITLO, sERROR} state_t;

    state_t                    state;
    logic [CW-1:0]             rr_ptr;
    logic [CW-1:0]             gnt_idx;
    logic [CW-1:0]             gnt_sel;
    logic [CW-1:0]             gnt_next;
    logic [CW-1:0]             cand;
    logic [C_SAMPLE_WIDTH-1:0] shift_reg;
    logic [2:0]                byte_cnt;
    logic [7:0]                tmo_cnt;
    logic [C_SAMPLE_WIDTH-1:0] samples [C_CHANNELS];

    for (genvar k = 0; k < C_CHANNELS; k++) begin : g_split
        assign samples[k] = sample[k*C_SAMPLE_WIDTH +: C_SAMPLE_WIDTH];
    end

    // Scan from the farthest offset back to the pointer so the last hit is the first in RR order.
    always_comb begin
        gnt_sel = '0;
        cand    = '0;
        for (int i = C_CHANNELS - 1; i >= 0; i--) begin
            cand = CW'((int'(rr_ptr) + i) % C_CHANNELS);
            if (req[cand]) gnt_sel = cand;
        end
        gnt_next = (gnt_sel == CW'(C_CHANNELS - 1)) ? '0 : gnt_sel + 1'b1;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state        <= sIDLE;
            rr_ptr       <= '0;
            gnt_idx      <= '0;
            shift_reg    <= '0;
            byte_cnt     <= '0;
            tmo_cnt      <= '0;
            ack          <= '0;
            tx_send      <= 1'b0;
            tx_data      <= 8'h00;
            frame_active <= 1'b0;
            error        <= 1'b0;
        end else begin
            ack <= '0;
            case (state)
                sIDLE: begin
                    if (|req && !tx_busy) begin
                        gnt_idx      <= gnt_sel;
                        rr_ptr       <= gnt_next;
                        ack          <= ACK_ONE << gnt_sel;
                        frame_active <= 1'b1;
                        state        <= sGRANT;
                    end
                end
                sGRANT: begin
                    // Sample is captured at the end of the ack cycle; later changes are ignored.
                    shift_reg <= samples[gnt_idx];
                    tx_data   <= {C_HEADER_TAG, 4'(gnt_idx)};
                    tx_send   <= 1'b1;
                    byte_cnt  <= '0;
                    state     <= sSEND;
                end
                sSEND: begin
                    tx_send <= 1'b0;
                    tmo_cnt <= '0;
                    state   <= sWAITHI;
                end
                sWAITHI: begin
                    // Counting the send cycle, error lands C_TIMEOUT cycles after tx_send.
                    if (tx_busy) begin
                        state <= sWAITLO;
                    end else if (tmo_cnt == 8'(C_TIMEOUT - 2)) begin
                        error        <= 1'b1;
                        frame_active <= 1'b0;
                        state        <= sERROR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                sWAITLO: begin
                    if (!tx_busy) begin
                        if (byte_cnt == 3'(NB - 1)) begin
                            frame_active <= 1'b0;
                            state        <= sIDLE;
                        end else begin
                            byte_cnt  <= byte_cnt + 3'd1;
                            tx_data   <= shift_reg[C_SAMPLE_WIDTH-1 -: 8];
                            shift_reg <= shift_reg << 8;
                            tx_send   <= 1'b1;
                            state     <= sSEND;
                        end
                    end
                end
                sERROR: begin
                    frame_active <= 1'b0;
                    state        <= sIDLE;
                end
                default: state <= sIDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Directed bench for uart_frame_scheduler with a small UART_Tx busy model that logs every sent byte.
module tb_uart_frame_scheduler;
    localparam int BYTE_CYC = 10;

    logic        clk = 1'b0;
    logic        rstb = 1'b1;
    logic [3:0]  req = '0;
    logic [63:0] sample = '0;
    logic [3:0]  ack;
    logic        tx_send;
    logic [7:0]  tx_data;
    logic        tx_busy = 1'b0;
    logic        frame_active;
    logic        error;

    int n_vec = 0;
    int n_miss = 0;
    int mode = 0;   // 0: normal UART, 1: busy stuck low, 2: busy stuck high
    int lag = 0;
    int bcnt = 0;
    logic [7:0] byte_q [$];

    typedef struct {
        logic [3:0]  req;
        logic [63:0] smp;
        logic [3:0]  ack;
        logic [7:0]  b0, b1, b2;
    } vec_t;
    vec_t tbl [5];

    uart_frame_scheduler dut (
        .clk(clk), .rstb(rstb), .req(req), .sample(sample), .ack(ack),
        .tx_send(tx_send), .tx_data(tx_data), .tx_busy(tx_busy),
        .frame_active(frame_active), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic check_byte(input string name, input int idx, input logic [7:0] exp);
        logic [31:0] act;
        act = (idx < byte_q.size()) ? 32'(byte_q[idx]) : 32'hFFFF_FFFF;
        check(name, act, 32'(exp));
    endtask

    // Returns the ack seen, or 0 if none appears within the bound.
    task automatic wait_ack(output logic [3:0] a);
        a = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ack != 4'b0) begin
                a = ack;
                return;
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!frame_active) return;
        end
    endtask

    // UART_Tx stand-in: busy rises 2 cycles after send and stays up BYTE_CYC cycles.
    always @(negedge clk) begin
        if (tx_send) begin
            byte_q.push_back(tx_data);
            check("send_while_busy", 32'(tx_busy), 32'd0);
        end
        if (mode == 0) begin
            if (tx_send) lag = 2;
            else if (lag > 0) begin
                lag--;
                if (lag == 0) begin
                    tx_busy = 1'b1;
                    bcnt = BYTE_CYC;
                end
            end else if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) tx_busy = 1'b0;
            end else tx_busy = 1'b0;
        end else begin
            lag = 0;
            bcnt = 0;
            tx_busy = (mode == 2);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] a;
        int n;
        tbl[0] = '{4'b0100, {16'h0000, 16'h1234, 16'h0000, 16'h0000}, 4'b0100, 8'hA2, 8'h12, 8'h34};
        tbl[1] = '{4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'hBEEF}, 4'b0001, 8'hA0, 8'hBE, 8'hEF};
        tbl[2] = '{4'b1000, {16'h00FF, 16'h0000, 16'h0000, 16'h0000}, 4'b1000, 8'hA3, 8'h00, 8'hFF};
        tbl[3] = '{4'b0110, {16'h0000, 16'hC3C3, 16'h5A5A, 16'h0000}, 4'b0010, 8'hA1, 8'h5A, 8'h5A};
        tbl[4] = '{4'b0110, {16'h0000, 16'hC3C3, 16'h5A5A, 16'h0000}, 4'b0100, 8'hA2, 8'hC3, 8'hC3};

        // Reset before any clock edge.
        #1 rstb = 1'b0;
        #2;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_tx_send", 32'(tx_send), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_frame_active", 32'(frame_active), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        repeat (2) @(negedge clk);
        rstb = 1'b1;

        // Fairness from pointer 0 with every channel requesting.
        @(negedge clk);
        byte_q.delete();
        sample = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_ack(a);
            check($sformatf("fair_ack%0d", i), 32'(a), 32'(4'b0001 << (i % 4)));
        end
        @(negedge clk);
        req = '0;
        wait_idle();
        check("fair_count", byte_q.size(), 32'd15);
        for (int i = 0; i < 5; i++) begin
            check_byte($sformatf("fair_hdr%0d", i), 3 * i, 8'hA0 | 8'(i % 4));
            check_byte($sformatf("fair_dat%0d", i), 3 * i + 1, 8'((i % 4) * 8'h11));
        end

        // Table of single frames; pointer starts at 1.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            byte_q.delete();
            req = tbl[i].req;
            sample = tbl[i].smp;
            wait_ack(a);
            check($sformatf("v%0d_ack", i), 32'(a), 32'(tbl[i].ack));
            @(negedge clk);
            req = '0;
            wait_idle();
            check($sformatf("v%0d_idle", i), 32'(frame_active), 32'd0);
            check($sformatf("v%0d_count", i), byte_q.size(), 32'd3);
            check_byte($sformatf("v%0d_b0", i), 0, tbl[i].b0);
            check_byte($sformatf("v%0d_b1", i), 1, tbl[i].b1);
            check_byte($sformatf("v%0d_b2", i), 2, tbl[i].b2);
        end

        // Sample changes one cycle after ack must not reach the frame.
        @(negedge clk);
        byte_q.delete();
        sample = {16'h0000, 16'h1234, 16'h0000, 16'h0000};
        req = 4'b0100;
        wait_ack(a);
        check("stab_ack", 32'(a), 32'b0100);
        @(negedge clk);
        sample[47:32] = 16'hFFFF;
        req = '0;
        wait_idle();
        check("stab_count", byte_q.size(), 32'd3);
        check_byte("stab_b1", 1, 8'h12);
        check_byte("stab_b2", 2, 8'h34);

        // Pointer wrap: ch3, then ch0 and ch1 raised mid-frame.
        @(negedge clk);
        byte_q.delete();
        req = 4'b1000;
        wait_ack(a);
        check("wrap_ack0", 32'(a), 32'b1000);
        @(negedge clk);
        req = 4'b0011;
        wait_ack(a);
        check("wrap_ack1", 32'(a), 32'b0001);
        wait_ack(a);
        check("wrap_ack2", 32'(a), 32'b0010);
        @(negedge clk);
        req = '0;
        wait_idle();
        check_byte("wrap_hdr0", 0, 8'hA3);
        check_byte("wrap_hdr1", 3, 8'hA0);
        check_byte("wrap_hdr2", 6, 8'hA1);

        // Handshake timeout with busy stuck low.
        @(negedge clk);
        mode = 1;
        byte_q.delete();
        sample = {16'h0000, 16'h5555, 16'h0000, 16'h0102};
        req = 4'b0100;
        wait_ack(a);
        check("tmo_ack", 32'(a), 32'b0100);
        @(negedge clk);
        req = '0;
        check("tmo_latency_send", 32'(tx_send), 32'd1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (error) break;
        end
        check("tmo_cycles", n, 32'd8);
        check("tmo_frame_active", 32'(frame_active), 32'd0);
        @(negedge clk);
        check("tmo_sticky", 32'(error), 32'd1);
        check("tmo_one_send", byte_q.size(), 32'd1);
        mode = 0;
        byte_q.delete();
        req = 4'b0001;
        wait_ack(a);
        check("tmo_next_ack", 32'(a), 32'b0001);
        @(negedge clk);
        req = '0;
        wait_idle();
        check_byte("tmo_next_hdr", 0, 8'hA0);
        check_byte("tmo_next_b1", 1, 8'h01);
        check_byte("tmo_next_b2", 2, 8'h02);
        check("tmo_still_error", 32'(error), 32'd1);

        // Reset during the second byte, released while the UART is still busy.
        @(negedge clk);
        byte_q.delete();
        sample = {16'h0000, 16'hABCD, 16'h7777, 16'h0000};
        req = 4'b0100;
        wait_ack(a);
        @(negedge clk);
        req = '0;
        for (int i = 0; i < 100; i++) begin
            if (byte_q.size() >= 2) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        #2;
        mode = 2;
        rstb = 1'b0;
        #1;
        check("mid_rst_frame_active", 32'(frame_active), 32'd0);
        check("mid_rst_tx_send", 32'(tx_send), 32'd0);
        check("mid_rst_tx_data", 32'(tx_data), 32'd0);
        check("mid_rst_error", 32'(error), 32'd0);
        check("mid_rst_ack", 32'(ack), 32'd0);
        @(negedge clk);
        req = 4'b0010;
        byte_q.delete();
        @(negedge clk);
        rstb = 1'b1;
        repeat (6) @(negedge clk);
        check("busy_blocks_start", byte_q.size(), 32'd0);
        mode = 0;
        wait_ack(a);
        check("post_rst_ack", 32'(a), 32'b0010);
        @(negedge clk);
        req = '0;
        wait_idle();
        check("post_rst_count", byte_q.size(), 32'd3);
        check_byte("post_rst_hdr", 0, 8'hA1);
        check_byte("post_rst_b1", 1, 8'h77);
        check_byte("post_rst_b2", 2, 8'h77);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
